holosynth_voice_alloc: RTL
==========================

// Module: holosynth_voice_alloc
// PURPOSE
// - Multitimbral polyphonic voice allocator, placed between the MIDI decoder and the voice/oscillator array.
// - Maps note events (channel, note, velocity) onto VOICES voice slots.
// - Tracks key-held, sustain-pedal and envelope-idle state per voice; drives keys_on/voice_free.
// - Steals the oldest voice when the pool is exhausted.
// PARAMETERS
// - VOICES    32  voice slots (>=2)
// - CHANNELS  16  MIDI channels tracked for sustain (1..16); events on ch>=CHANNELS are dropped
// - STEAL_EN  1   1: steal when no free voice; 0: drop the event
// - STAMP_W   16  width of the allocation age stamp
// PORTS
// - fpga_clk        in   1          system clock
// - reset           in   1          synchronous, active-high
// - ev_valid        in   1          event valid
// - ev_ready        out  1          allocator accepts event (high only in IDLE)
// - ev_type         in   2          00 note-off, 01 note-on, 10 sustain, 11 all-notes-off
// - ev_chan         in   4          MIDI channel
// - ev_note         in   7          note number
// - ev_vel          in   7          velocity; for sustain, bit6=pedal down
// - env_idle        in   VOICES     envelope of voice v has finished release
// - keys_on         out  VOICES     key held on voice v
// - voice_free      out  VOICES     ~keys_on & ~sustained & env_idle
// - asg_valid       out  1          one-cycle pulse: voice assigned
// - asg_voice       out  clog2(V)   assigned voice index
// - asg_chan/asg_note/asg_vel  out  4/7/7  event copied to the assigned voice
// - asg_steal       out  1          qualifies asg_valid: a held/sustained voice was stolen
// - ev_drop         out  1          one-cycle pulse: event discarded
// BEHAVIOUR
// - Reset (sync): state=IDLE.
//   - keys_on, sustained, pedal[CHANNELS], voice tables and stamp counter cleared.
//   - asg_* and ev_drop = 0; ev_ready = 1 from the first cycle after reset.
// - FSM: IDLE -> SCAN -> COMMIT -> IDLE.
//   - Handshake: ev_valid & ev_ready in IDLE latches the event; ev_ready is low in SCAN and COMMIT.
//   - SCAN inspects one voice per cycle, v = 0..VOICES-1 (VOICES cycles).
//   - COMMIT is one cycle. asg_valid/ev_drop pulse in COMMIT.
//   - Total latency from accept to pulse = VOICES+1 cycles. Back-to-back throughput = one event per VOICES+2 cycles.
// - Note-on with vel=0 is treated as note-off.
// - Note-on candidate priority, evaluated during SCAN:
//   1. voice already holding the same chan/note (retrigger)
//   2. lowest-index voice with voice_free=1
//   3. released voice (~keys_on & ~sustained, env not idle) with the oldest stamp
//   4. STEAL_EN=1: oldest voice overall, and asg_steal=1
//   - If no candidate is found (STEAL_EN=0 and all voices busy): ev_drop=1 and no state change.
// - Age: per-voice stamp, written with stamp_ctr at assignment.
//   - stamp_ctr increments once per assignment and wraps.
//   - Age = stamp_ctr - stamp[v], modulo 2^STAMP_W, so comparison is wrap-safe.
//   - Ties resolve to the lower index.
// - On commit, the chosen voice gets: keys_on=1, sustained=0, chan/note stored.
// - Note-off: every voice with keys_on & matching chan/note clears keys_on.
//   - If pedal[chan]=1, that voice's sustained bit is set instead.
//   - No match: silent, no pulse.
// - Sustain with vel[6]=1: pedal[chan]=1.
// - Sustain with vel[6]=0: pedal[chan]=0 and sustained cleared on all voices of chan.
// - All-notes-off: keys_on and sustained cleared for every voice of chan; pedal unchanged.
// - Non-note events take the same SCAN/COMMIT path but produce no asg_valid.
// - Per-voice bit updates are applied in COMMIT from a VOICES-wide match mask built during SCAN.
// - env_idle is sampled at the cycle voice v is scanned. A later change within the same scan is not seen.
// - keys_on and voice_free are registered and change only in COMMIT or reset.
// - Reset asserted in SCAN or COMMIT aborts the event: no pulse, all state cleared.
// STRUCTURE
// - Package holosynth_pkg:
//   - EV_NOTE_OFF/EV_NOTE_ON/EV_SUSTAIN/EV_ALL_OFF localparams
//   - voice_entry_t {chan, note, stamp}
// - Sub-module holosynth_oldest_track: running best-candidate register (index, age, class) updated once per SCAN cycle.
// - Remaining logic (FSM, voice tables, pedal register) lives in this module.
// TESTING
// 1. Reset, then note-on ch0 n60 v100.
//    -> asg_valid at accept+VOICES+1, asg_voice=0, keys_on=...0001, asg_steal=0.
// 2. Note-on ch0 n60, then ch0 n60 again.
//    -> both assign voice 0 (retrigger); keys_on still a single bit.
// 3. VOICES note-ons (distinct notes), then one more with STEAL_EN=1.
//    -> voice 0 stolen, asg_steal=1. With STEAL_EN=0 -> ev_drop=1, tables unchanged.
// 4. Pedal down ch2, note-on/off ch2 n64.
//    -> keys_on=0 and voice_free=0. Pedal up -> voice_free=1 once env_idle=1.
// 5. Drive stamp_ctr to 2^STAMP_W-2 and allocate across the wrap.
//    -> oldest voice is still chosen correctly on steal.
// 6. Assert reset during SCAN.
//    -> no asg_valid, keys_on=0, ev_ready=1 on the next cycle.

Source files
------------

// File: rtl/holosynth_pkg.sv
// Shared types for the holosynth voice allocator: event codes, voice table
// entry, FSM states and the candidate classes used while scanning voices.
package holosynth_pkg;

  localparam logic [1:0] EV_NOTE_OFF = 2'b00;
  localparam logic [1:0] EV_NOTE_ON  = 2'b01;
  localparam logic [1:0] EV_SUSTAIN  = 2'b10;
  localparam logic [1:0] EV_ALL_OFF  = 2'b11;

  // Stamps are stored at this width; the allocator uses the low STAMP_W bits.
  localparam int STAMP_MAX_W = 16;

  typedef struct packed {
    logic [3:0]             chan;
    logic [6:0]             note;
    logic [STAMP_MAX_W-1:0] stamp;
  } voice_entry_t;

  typedef struct packed {
    logic [3:0] chan;
    logic [6:0] note;
    logic [6:0] vel;
  } note_ev_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;

  // Decoded operation; note-on with velocity 0 is folded into OP_OFF.
  typedef enum logic [2:0] {OP_ON, OP_OFF, OP_SUS, OP_ALL, OP_DROP} op_t;

  // Higher value wins; ages only break ties inside REL and BUSY.
  typedef enum logic [1:0] {
    CLS_BUSY   = 2'd0,
    CLS_REL    = 2'd1,
    CLS_FREE   = 2'd2,
    CLS_RETRIG = 2'd3
  } cand_cls_t;

endpackage

// File: rtl/holosynth_voice_alloc_if.sv
// Event in / assignment out bus between the MIDI decoder (master) and the
// voice allocator (slave).
interface holosynth_voice_alloc_if #(
  parameter int VOICES = 32
);
  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic          ev_valid;
  logic          ev_ready;
  logic [1:0]    ev_type;
  logic [3:0]    ev_chan;
  logic [6:0]    ev_note;
  logic [6:0]    ev_vel;
  logic          asg_valid;
  logic [IW-1:0] asg_voice;
  logic [3:0]    asg_chan;
  logic [6:0]    asg_note;
  logic [6:0]    asg_vel;
  logic          asg_steal;
  logic          ev_drop;

  modport master (
    output ev_valid, ev_type, ev_chan, ev_note, ev_vel,
    input  ev_ready, asg_valid, asg_voice, asg_chan, asg_note, asg_vel,
           asg_steal, ev_drop
  );

  modport slave (
    input  ev_valid, ev_type, ev_chan, ev_note, ev_vel,
    output ev_ready, asg_valid, asg_voice, asg_chan, asg_note, asg_vel,
           asg_steal, ev_drop
  );

endinterface

// File: rtl/holosynth_oldest_track.sv
// Running best-candidate register for the voice scan. One candidate is offered
// per cycle; a higher class always wins, and within the aged classes (released,
// busy) a strictly older voice wins so ties stay with the lower index.
module holosynth_oldest_track
  import holosynth_pkg::*;
#(
  parameter int IW    = 5,
  parameter int AGE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic             cand_vld,
  input  logic [IW-1:0]    cand_idx,
  input  cand_cls_t        cand_cls,
  input  logic [AGE_W-1:0] cand_age,
  output logic             best_vld,
  output logic [IW-1:0]    best_idx,
  output cand_cls_t        best_cls
);

  logic             best_vld_q, best_vld_d;
  logic [IW-1:0]    best_idx_q, best_idx_d;
  cand_cls_t        best_cls_q, best_cls_d;
  logic [AGE_W-1:0] best_age_q, best_age_d;
  logic             take;

  // Decide whether the offered voice beats the current best and update it
  always_comb begin
    take = 1'b0;
    if (cand_vld) begin
      if (!best_vld_q)                 take = 1'b1;
      else if (cand_cls > best_cls_q)  take = 1'b1;
      else if (cand_cls == best_cls_q &&
               (cand_cls == CLS_REL || cand_cls == CLS_BUSY) &&
               cand_age > best_age_q)  take = 1'b1;
    end
    best_vld_d = best_vld_q;
    best_idx_d = best_idx_q;
    best_cls_d = best_cls_q;
    best_age_d = best_age_q;
    if (clr) begin
      best_vld_d = 1'b0;
    end else if (upd && take) begin
      best_vld_d = 1'b1;
      best_idx_d = cand_idx;
      best_cls_d = cand_cls;
      best_age_d = cand_age;
    end
  end

  // Best-candidate state
  always_ff @(posedge clk) begin
    if (rst) begin
      best_vld_q <= 1'b0;
      best_idx_q <= '0;
      best_cls_q <= CLS_BUSY;
      best_age_q <= '0;
    end else begin
      best_vld_q <= best_vld_d;
      best_idx_q <= best_idx_d;
      best_cls_q <= best_cls_d;
      best_age_q <= best_age_d;
    end
  end

  assign best_vld = best_vld_q;
  assign best_idx = best_idx_q;
  assign best_cls = best_cls_q;

endmodule

// File: rtl/holosynth_voice_alloc.sv
// Multitimbral voice allocator. Each accepted event walks all voices one per
// cycle (SCAN), building a match mask and a best allocation candidate, then
// applies every table change in a single COMMIT cycle.
module holosynth_voice_alloc
  import holosynth_pkg::*;
#(
  parameter int VOICES   = 32,
  parameter int CHANNELS = 16,
  parameter int STEAL_EN = 1,
  parameter int STAMP_W  = 16
) (
  input  logic                  fpga_clk,
  input  logic                  reset,
  holosynth_voice_alloc_if.slave bus,
  input  logic [VOICES-1:0]     env_idle,
  output logic [VOICES-1:0]     keys_on,
  output logic [VOICES-1:0]     voice_free
);

  localparam int IW = $clog2(VOICES);

  state_t                    state_q, state_d;
  logic                      ev_ready_q, ev_ready_d;
  note_ev_t                  ev_q, ev_d;
  op_t                       op_q, op_d;
  logic [IW-1:0]             scan_idx_q, scan_idx_d;
  logic [VOICES-1:0]         match_q, match_d;
  logic [VOICES-1:0]         idle_q, idle_d;
  logic [VOICES-1:0]         keys_on_q, keys_on_d;
  logic [VOICES-1:0]         sus_q, sus_d;
  logic [VOICES-1:0]         free_q, free_d;
  logic [CHANNELS-1:0]       pedal_q, pedal_d;
  voice_entry_t [VOICES-1:0] entry_q, entry_d;
  logic [STAMP_W-1:0]        stamp_ctr_q, stamp_ctr_d;
  logic                      asg_valid_q, asg_valid_d;
  logic [IW-1:0]             asg_voice_q, asg_voice_d;
  note_ev_t                  asg_ev_q, asg_ev_d;
  logic                      asg_steal_q, asg_steal_d;
  logic                      ev_drop_q, ev_drop_d;

  // Scan-side view of the voice under inspection
  voice_entry_t              cur_ent;
  logic                      cur_act, chan_hit, note_hit, scan_hit;
  logic [STAMP_W-1:0]        cur_age;
  logic                      cand_vld;
  cand_cls_t                 cand_cls;
  logic                      trk_clr, trk_upd, best_vld;
  logic [IW-1:0]             best_idx;
  cand_cls_t                 best_cls;

  // Classify the voice under scan for the tracker and the commit mask
  always_comb begin
    cur_ent  = entry_q[scan_idx_q];
    cur_act  = keys_on_q[scan_idx_q] | sus_q[scan_idx_q];
    chan_hit = (cur_ent.chan == ev_q.chan);
    note_hit = chan_hit && (cur_ent.note == ev_q.note);
    // Modular difference keeps the age correct across stamp counter wrap
    cur_age  = stamp_ctr_q - cur_ent.stamp[STAMP_W-1:0];
    cand_vld = 1'b0;
    cand_cls = CLS_BUSY;
    scan_hit = 1'b0;
    case (op_q)
      OP_ON: begin
        if (cur_act && note_hit) begin
          cand_vld = 1'b1;
          cand_cls = CLS_RETRIG;
        end else if (!cur_act && env_idle[scan_idx_q]) begin
          cand_vld = 1'b1;
          cand_cls = CLS_FREE;
        end else if (!cur_act) begin
          cand_vld = 1'b1;
          cand_cls = CLS_REL;
        end else begin
          cand_vld = (STEAL_EN != 0);
          cand_cls = CLS_BUSY;
        end
      end
      OP_OFF:  scan_hit = keys_on_q[scan_idx_q] && note_hit;
      OP_SUS:  scan_hit = sus_q[scan_idx_q] && chan_hit;
      OP_ALL:  scan_hit = chan_hit;
      default: scan_hit = 1'b0;
    endcase
  end

  assign trk_upd = (state_q == ST_SCAN);

  holosynth_oldest_track #(
    .IW    (IW),
    .AGE_W (STAMP_W)
  ) u_track (
    .clk      (fpga_clk),
    .rst      (reset),
    .clr      (trk_clr),
    .upd      (trk_upd),
    .cand_vld (cand_vld),
    .cand_idx (scan_idx_q),
    .cand_cls (cand_cls),
    .cand_age (cur_age),
    .best_vld (best_vld),
    .best_idx (best_idx),
    .best_cls (best_cls)
  );

  // FSM next state: accept in IDLE, walk voices in SCAN, apply in COMMIT
  always_comb begin
    state_d     = state_q;
    ev_ready_d  = ev_ready_q;
    ev_d        = ev_q;
    op_d        = op_q;
    scan_idx_d  = scan_idx_q;
    match_d     = match_q;
    idle_d      = idle_q;
    keys_on_d   = keys_on_q;
    sus_d       = sus_q;
    free_d      = free_q;
    pedal_d     = pedal_q;
    entry_d     = entry_q;
    stamp_ctr_d = stamp_ctr_q;
    asg_valid_d = 1'b0;
    asg_voice_d = '0;
    asg_ev_d    = '0;
    asg_steal_d = 1'b0;
    ev_drop_d   = 1'b0;
    trk_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ev_valid && ev_ready_q) begin
          ev_d = '{chan: bus.ev_chan, note: bus.ev_note, vel: bus.ev_vel};
          if (int'(bus.ev_chan) >= CHANNELS) begin
            op_d = OP_DROP;
          end else begin
            case (bus.ev_type)
              EV_NOTE_ON:  op_d = (bus.ev_vel == 7'd0) ? OP_OFF : OP_ON;
              EV_NOTE_OFF: op_d = OP_OFF;
              EV_SUSTAIN:  op_d = OP_SUS;
              default:     op_d = OP_ALL;
            endcase
          end
          state_d    = ST_SCAN;
          ev_ready_d = 1'b0;
          scan_idx_d = '0;
          match_d    = '0;
          idle_d     = '0;
          trk_clr    = 1'b1;
        end
      end
      ST_SCAN: begin
        match_d[scan_idx_q] = scan_hit;
        idle_d[scan_idx_q]  = env_idle[scan_idx_q];
        if (scan_idx_q == IW'(VOICES - 1)) state_d = ST_COMMIT;
        else                               scan_idx_d = scan_idx_q + IW'(1);
      end
      ST_COMMIT: begin
        state_d    = ST_IDLE;
        ev_ready_d = 1'b1;
        case (op_q)
          OP_ON: begin
            if (best_vld) begin
              keys_on_d[best_idx] = 1'b1;
              sus_d[best_idx]     = 1'b0;
              entry_d[best_idx]   = '{chan:  ev_q.chan,
                                      note:  ev_q.note,
                                      stamp: STAMP_MAX_W'(stamp_ctr_q)};
              stamp_ctr_d         = stamp_ctr_q + STAMP_W'(1);
              asg_valid_d         = 1'b1;
              asg_voice_d         = best_idx;
              asg_ev_d            = ev_q;
              asg_steal_d         = (best_cls == CLS_BUSY);
            end else begin
              ev_drop_d = 1'b1;
            end
          end
          OP_OFF: begin
            keys_on_d = keys_on_q & ~match_q;
            if (pedal_q[ev_q.chan]) sus_d = sus_q | match_q;
          end
          OP_SUS: begin
            if (ev_q.vel[6]) begin
              pedal_d[ev_q.chan] = 1'b1;
            end else begin
              pedal_d[ev_q.chan] = 1'b0;
              sus_d              = sus_q & ~match_q;
            end
          end
          OP_ALL: begin
            keys_on_d = keys_on_q & ~match_q;
            sus_d     = sus_q & ~match_q;
          end
          default: ev_drop_d = 1'b1;
        endcase
        // A dropped event leaves every table, including voice_free, untouched
        if (!ev_drop_d) free_d = ~keys_on_d & ~sus_d & idle_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All allocator state; reset aborts any event in flight
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ev_ready_q  <= 1'b1;
      ev_q        <= '0;
      op_q        <= OP_ON;
      scan_idx_q  <= '0;
      match_q     <= '0;
      idle_q      <= '0;
      keys_on_q   <= '0;
      sus_q       <= '0;
      free_q      <= env_idle;
      pedal_q     <= '0;
      entry_q     <= '0;
      stamp_ctr_q <= '0;
      asg_valid_q <= 1'b0;
      asg_voice_q <= '0;
      asg_ev_q    <= '0;
      asg_steal_q <= 1'b0;
      ev_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ev_ready_q  <= ev_ready_d;
      ev_q        <= ev_d;
      op_q        <= op_d;
      scan_idx_q  <= scan_idx_d;
      match_q     <= match_d;
      idle_q      <= idle_d;
      keys_on_q   <= keys_on_d;
      sus_q       <= sus_d;
      free_q      <= free_d;
      pedal_q     <= pedal_d;
      entry_q     <= entry_d;
      stamp_ctr_q <= stamp_ctr_d;
      asg_valid_q <= asg_valid_d;
      asg_voice_q <= asg_voice_d;
      asg_ev_q    <= asg_ev_d;
      asg_steal_q <= asg_steal_d;
      ev_drop_q   <= ev_drop_d;
    end
  end

  assign bus.ev_ready  = ev_ready_q;
  assign bus.asg_valid = asg_valid_q;
  assign bus.asg_voice = asg_voice_q;
  assign bus.asg_chan  = asg_ev_q.chan;
  assign bus.asg_note  = asg_ev_q.note;
  assign bus.asg_vel   = asg_ev_q.vel;
  assign bus.asg_steal = asg_steal_q;
  assign bus.ev_drop   = ev_drop_q;
  assign keys_on       = keys_on_q;
  assign voice_free    = free_q;

endmodule
